// File: rtl/sec_disp_pkg.sv
// Shared definitions for the seconds display driver: widths, FSM encoding,
// digit payload layout and the 7-segment encoder.
package sec_disp_pkg;

    localparam int unsigned VAL_W = 6;
    localparam int unsigned BCD_W = 8;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Two BCD digits as produced by the converter.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Active-high segment codes {g,f,e,d,c,b,a} for digits 0..9.
    localparam logic [SEG_W-1:0] SEG_CODE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Active-high code for one BCD digit; blank or non-decimal gives all off.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] bcd, input logic blank);
        logic [SEG_W-1:0] code;
        code = '0;
        if (!blank && (bcd <= 4'd9)) begin
            code = SEG_CODE[bcd];
        end
        return code;
    endfunction

endpackage

// File: rtl/sec_display_driver_if.sv
// Display-side signal bundle.
//   VALUE    : seconds count from the timer (asynchronous to CLOCK)
//   BLANK_LZ : blank the tens digit when it is zero
//   SEG      : segment drive {g,f,e,d,c,b,a}
//   DIG      : digit enables, [0] = ones, [1] = tens
//   BUSY     : conversion in flight
// master = timer/host side, slave = display driver.
interface sec_display_driver_if;
    import sec_disp_pkg::*;

    logic [VAL_W-1:0] VALUE;
    logic             BLANK_LZ;
    logic [SEG_W-1:0] SEG;
    logic [DIG_W-1:0] DIG;
    logic             BUSY;

    modport master (output VALUE, BLANK_LZ, input SEG, DIG, BUSY);
    modport slave  (input VALUE, BLANK_LZ, output SEG, DIG, BUSY);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit binary to 2-digit BCD converter (double dabble, one step
// per clock) with capture of the last accepted value.
//   CLOCK, NRESET : clock, async active-low reset
//   START         : input is stable this cycle (may be held high)
//   BIN           : binary value to convert
//   BUSY          : conversion in flight (SHIFT and LOAD states)
//   DONE          : high in the LOAD cycle; BCD is final while DONE is high
//   BCD           : {tens, ones}
module bin2bcd_seq
    import sec_disp_pkg::*;
(
    input  logic             CLOCK,
    input  logic             NRESET,
    input  logic             START,
    input  logic [VAL_W-1:0] BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [BCD_W-1:0] BCD
);

    localparam int unsigned SR_W   = BCD_W + VAL_W;
    localparam int unsigned STEP_W = 3;

    state_e            state_q, state_d;
    logic [VAL_W-1:0]  last_q, last_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SR_W-1:0]   adj;

    // State register.
    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
            sr_q    <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state and datapath.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sr_d    = sr_q;
        step_d  = step_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Add-3 correction on both BCD nibbles before the shift.
        adj = sr_q;
        if (adj[SR_W-1 -: 4] >= 4'd5) begin
            adj[SR_W-1 -: 4] = adj[SR_W-1 -: 4] + 4'd3;
        end
        if (adj[VAL_W+3 -: 4] >= 4'd5) begin
            adj[VAL_W+3 -: 4] = adj[VAL_W+3 -: 4] + 4'd3;
        end

        case (state_q)
            ST_IDLE: begin
                // A new value only counts once it is stable and differs from the last one.
                if (START && (BIN != last_q)) begin
                    last_d  = BIN;
                    sr_d    = {BCD_W'(0), BIN};
                    step_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d   = {adj[SR_W-2:0], 1'b0};
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(VAL_W - 1)) begin
                    state_d = ST_LOAD;
                    done_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign BCD  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/sec_display_driver.sv
// Two-digit multiplexed 7-segment driver for the timer seconds count.
//   CLOCK, NRESET : clock, async active-low reset
//   bus.VALUE     : seconds count, resynchronised here
//   bus.BLANK_LZ  : blank a zero tens digit
//   bus.SEG/DIG   : registered segment and digit drive (polarity by parameter)
//   bus.BUSY      : conversion in flight
module sec_display_driver
    import sec_disp_pkg::*;
#(
    parameter int unsigned SCAN_CYCLE     = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                 CLOCK,
    input  logic                 NRESET,
    sec_display_driver_if.slave  bus
);

    localparam int unsigned      CNT_W   = (SCAN_CYCLE > 1) ? $clog2(SCAN_CYCLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_CYCLE - 1);
    localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [DIG_W-1:0] DIG_OFF = {DIG_W{DIG_ACTIVE_LOW}};

    logic [VAL_W-1:0] s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    bcd_t             digits_q, digits_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [DIG_W-1:0] dig_q, dig_d;

    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic             wrap;
    logic [3:0]       cur_digit;
    logic             blank;

    bin2bcd_seq u_conv (
        .CLOCK  (CLOCK),
        .NRESET (NRESET),
        .START  (s1_q == s2_q),
        .BIN    (s2_q),
        .BUSY   (conv_busy),
        .DONE   (conv_done),
        .BCD    (conv_bcd)
    );

    // Registers: synchroniser, scan, digits, outputs.
    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            digits_q <= '0;
            seg_q    <= SEG_OFF;
            dig_q    <= DIG_OFF;
        end else begin
            s1_q     <= bus.VALUE;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            digits_q <= digits_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end

    // Scan prescaler, digit select and output encoding.
    always_comb begin
        wrap     = (cnt_q == CNT_MAX);
        cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
        sel_d    = sel_q ^ wrap;
        digits_d = conv_done ? bcd_t'(conv_bcd) : digits_q;

        cur_digit = sel_q ? digits_q.tens : digits_q.ones;
        blank     = sel_q && bus.BLANK_LZ && (digits_q.tens == 4'd0);
        seg_d     = seg_encode(cur_digit, blank) ^ SEG_OFF;

        // Digits go dark for the cycle after a select change to avoid ghosting.
        dig_d = wrap ? DIG_OFF : ((sel_q ? 2'b10 : 2'b01) ^ DIG_OFF);
    end

    assign bus.SEG  = seg_q;
    assign bus.DIG  = dig_q;
    assign bus.BUSY = conv_busy;

endmodule

// File: tb/tb_sec_display_driver.sv
// Self-checking bench for sec_display_driver (SCAN_CYCLE = 4, active-low drive).
module tb_sec_display_driver;

    logic clk;
    logic rst_n;

    sec_display_driver_if bus ();

    sec_display_driver #(
        .SCAN_CYCLE     (4),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .CLOCK  (clk),
        .NRESET (rst_n),
        .bus    (bus)
    );

    typedef struct {
        int tens;
        int ones;
        bit blank;
    } disp_exp_t;

    disp_exp_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low segment pattern for a decimal digit.
    function automatic logic [6:0] seg_model(input int d);
        logic [6:0] c;
        case (d)
            0: c = 7'h3F;
            1: c = 7'h06;
            2: c = 7'h5B;
            3: c = 7'h4F;
            4: c = 7'h66;
            5: c = 7'h6D;
            6: c = 7'h7D;
            7: c = 7'h07;
            8: c = 7'h7F;
            9: c = 7'h6F;
            default: c = 7'h00;
        endcase
        return ~c;
    endfunction

    // Pop one expectation and check both digit slots over 8 consecutive samples,
    // starting with the current sample.
    task automatic check_display(input string tag);
        disp_exp_t  e;
        logic [6:0] want_t, want_o;
        bit         got_t, got_o;
        got_t = 0;
        got_o = 0;
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e      = sb_q.pop_front();
        want_t = (e.blank && e.tens == 0) ? 7'h7F : seg_model(e.tens);
        want_o = seg_model(e.ones);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (bus.DIG === 2'b01 && !got_t) begin
                got_t = 1; n_checks++;
                if (bus.SEG !== want_t) begin
                    n_fail++;
                    $display("FAIL %s tens SEG: got %h want %h", tag, bus.SEG, want_t);
                end
            end
            if (bus.DIG === 2'b10 && !got_o) begin
                got_o = 1; n_checks++;
                if (bus.SEG !== want_o) begin
                    n_fail++;
                    $display("FAIL %s ones SEG: got %h want %h", tag, bus.SEG, want_o);
                end
            end
        end
        if (!got_t) begin n_checks++; n_fail++; $display("FAIL %s tens slot: not seen, want DIG 01", tag); end
        if (!got_o) begin n_checks++; n_fail++; $display("FAIL %s ones slot: not seen, want DIG 10", tag); end
    endtask

    // Called at a negedge with VALUE already presented; checks BUSY over E0..E9.
    task automatic check_latency(input string tag);
        logic want;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            want = (e >= 2 && e <= 8);
            n_checks++;
            if (bus.BUSY !== want) begin
                n_fail++;
                $display("FAIL %s BUSY after E%0d: got %b want %b", tag, e, bus.BUSY, want);
            end
        end
    endtask

    task automatic wait_busy_low(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.BUSY === 1'b0) seen = 1;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL %s wait BUSY low: got %b want 0 within 30 cycles", tag, bus.BUSY);
        end
    endtask

    task automatic test_reset();
        logic [1:0] want_dig;
        int  mcnt;
        bit  msel, wrap;
        rst_n        = 1'b0;
        bus.VALUE    = '0;
        bus.BLANK_LZ = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 3;
        if (bus.SEG  !== 7'h7F) begin n_fail++; $display("FAIL reset SEG: got %h want 7f", bus.SEG); end
        if (bus.DIG  !== 2'b11) begin n_fail++; $display("FAIL reset DIG: got %b want 11", bus.DIG); end
        if (bus.BUSY !== 1'b0)  begin n_fail++; $display("FAIL reset BUSY: got %b want 0", bus.BUSY); end
        rst_n = 1'b1;
        mcnt  = 0;
        msel  = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            wrap     = (mcnt == 3);
            want_dig = wrap ? 2'b11 : (msel ? 2'b01 : 2'b10);
            msel     = msel ^ wrap;
            mcnt     = wrap ? 0 : mcnt + 1;
            n_checks++;
            if (bus.DIG !== want_dig) begin
                n_fail++;
                $display("FAIL scan DIG cycle %0d: got %b want %b", i, bus.DIG, want_dig);
            end
            if (want_dig == 2'b10) begin
                n_checks++;
                if (bus.SEG !== 7'h40) begin n_fail++; $display("FAIL scan ones SEG: got %h want 40", bus.SEG); end
            end
            if (want_dig == 2'b01) begin
                n_checks++;
                if (bus.SEG !== 7'h7F) begin n_fail++; $display("FAIL scan tens SEG: got %h want 7f", bus.SEG); end
            end
        end
    endtask

    task automatic test_convert(input int v, input bit blank, input string tag);
        @(negedge clk);
        bus.VALUE    = 6'(v);
        bus.BLANK_LZ = blank;
        sb_q.push_back('{v / 10, v % 10, blank});
        check_latency(tag);
        @(posedge clk); #1;
        check_display(tag);
    endtask

    task automatic test_blank_off();
        @(negedge clk);
        bus.BLANK_LZ = 1'b0;
        sb_q.push_back('{0, 9, 1'b0});
        @(posedge clk); #1;
        check_display("blank_off_9");
        @(negedge clk);
        bus.BLANK_LZ = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.VALUE = 6'd12;
        sb_q.push_back('{1, 2, 1'b1});
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b first BUSY: got %b want 1", bus.BUSY); end
        @(negedge clk);
        bus.VALUE = 6'd45;
        sb_q.push_back('{4, 5, 1'b1});
        wait_busy_low("b2b_first");
        @(posedge clk); #1;
        n_checks++;
        if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b restart BUSY: got %b want 1", bus.BUSY); end
        check_display("b2b_first");
        wait_busy_low("b2b_second");
        @(posedge clk); #1;
        check_display("b2b_second");
    endtask

    task automatic test_glitch();
        int rises;
        logic prev;
        // One-clock glitch: never stable in the synchroniser.
        @(negedge clk); bus.VALUE = 6'd21;
        @(negedge clk); bus.VALUE = 6'd20;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL glitch1 BUSY cycle %0d: got %b want 0", i, bus.BUSY); end
        end
        sb_q.push_back('{2, 0, 1'b1});
        check_display("glitch1");
        // Two-clock glitch: stable long enough to convert, then converts back.
        @(negedge clk); bus.VALUE = 6'd21;
        @(negedge clk);
        @(negedge clk); bus.VALUE = 6'd20;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.BUSY === 1'b1 && prev === 1'b0) rises++;
            prev = bus.BUSY;
        end
        n_checks++;
        if (rises != 2) begin n_fail++; $display("FAIL glitch2 conversions: got %0d want 2", rises); end
        sb_q.push_back('{2, 0, 1'b1});
        check_display("glitch2");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.VALUE = 6'd51;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (bus.SEG  !== 7'h7F) begin n_fail++; $display("FAIL midreset SEG: got %h want 7f", bus.SEG); end
        if (bus.DIG  !== 2'b11) begin n_fail++; $display("FAIL midreset DIG: got %b want 11", bus.DIG); end
        if (bus.BUSY !== 1'b0)  begin n_fail++; $display("FAIL midreset BUSY: got %b want 0", bus.BUSY); end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{5, 1, 1'b1});
        check_latency("midreset");
        @(posedge clk); #1;
        check_display("midreset");
    endtask

    initial begin
        test_reset();
        test_convert(37, 1'b1, "v37");
        test_convert(63, 1'b1, "v63");
        test_convert(59, 1'b1, "v59");
        test_convert(9,  1'b1, "v9_blank");
        test_blank_off();
        test_back_to_back();
        test_convert(20, 1'b1, "v20");
        test_glitch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
